mux_sequencer: RTL and testbench

Stage sequencer at the far end of the init handshake. It consumes `rstsig` and the edge clock from the init block, walks a mux select through `STAGES` positions, and returns `muxlast` to init so init knows when a new run may be started. It sits between the init block and the ALU operand/result muxes and owns the only `sel` counter in the datapath.

---
 rtl/mux_sequencer.sv | 101 ++++++++++
 tb/tb_mux_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_sequencer.sv
// Stage sequencer: walks the mux select through STAGES positions per init run.
// Optional free-running mode via `MUX_SEQUENCER_WRAP_EN (LAST wraps to RUN, not IDLE).
module mux_sequencer #(
  parameter int STAGES = 8,
  parameter int SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rstsig,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             muxlast,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(STAGES - 1);
  localparam logic [1:0]       S_START  = (STAGES == 1) ? S_LAST : S_RUN;
`ifdef MUX_SEQUENCER_WRAP_EN
  localparam logic [1:0]       S_AFTER  = S_START;
`else
  localparam logic [1:0]       S_AFTER  = S_IDLE;
`endif

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             muxlast_q, muxlast_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step_q;
  logic             step_edge;
  logic [SEL_W-1:0] sel_inc;

  assign step_edge = step & ~step_q;
  assign sel_inc   = sel_q + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    if (rstsig) begin
      // Restart wins over any step seen in the same cycle.
      state_d = S_START;
      sel_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (step_edge) begin
            sel_d = sel_inc;
            if (sel_inc == SEL_LAST) state_d = S_LAST;
          end
        end
        S_LAST: begin
          if (step_edge) begin
            done_d  = 1'b1;
            sel_d   = '0;
            state_d = S_AFTER;
          end
        end
        default: begin
          state_d = S_IDLE;
          sel_d   = '0;
        end
      endcase
    end
    // Outputs are registered, so derive them from the next state.
    muxlast_d = (state_d != S_RUN);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      muxlast_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      muxlast_q <= muxlast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      step_q    <= step;
    end
  end

  assign sel     = sel_q;
  assign muxlast = muxlast_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed bench for mux_sequencer (STAGES=8): vector table plus reset corner sequences.
module tb_mux_sequencer;

  localparam int STAGES = 8;
  localparam int SEL_W  = 3;
`ifdef MUX_SEQUENCER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             rstsig;
  logic             step;
  logic [SEL_W-1:0] sel;
  logic             muxlast;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  typedef struct {
    logic             rs;
    logic             st;
    logic [SEL_W-1:0] sel;
    logic             ml;
    logic             bz;
    logic             dn;
  } vec_t;

  vec_t tbl[$];

  mux_sequencer #(.STAGES(STAGES), .SEL_W(SEL_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rstsig (rstsig),
    .step   (step),
    .sel    (sel),
    .muxlast(muxlast),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input int e_sel, input int e_ml,
                         input int e_bz, input int e_dn);
    chk({tag, ".sel"}, idx, int'(sel), e_sel);
    chk({tag, ".muxlast"}, idx, int'(muxlast), e_ml);
    chk({tag, ".busy"}, idx, int'(busy), e_bz);
    chk({tag, ".done"}, idx, int'(done), e_dn);
  endtask

  function automatic void add(input logic rs, input logic st, input int s, input logic ml,
                              input logic bz, input logic dn);
    vec_t v;
    v.rs = rs; v.st = st; v.sel = SEL_W'(s); v.ml = ml; v.bz = bz; v.dn = dn;
    tbl.push_back(v);
  endfunction

  // One step pulse (2 high, 2 low) that is the k-th edge of a run.
  function automatic void add_pulse(input int k);
    if (k < STAGES) begin
      for (int c = 0; c < 4; c++)
        add(1'b0, (c < 2), k, (k == STAGES - 1), 1'b1, 1'b0);
    end else begin
      add(1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
      tbl[tbl.size() - 1].ml = !WRAP;
      tbl[tbl.size() - 1].bz = WRAP;
      tbl[tbl.size() - 1].dn = 1'b1;
      for (int c = 1; c < 4; c++)
        add(1'b0, (c < 2), 0, !WRAP, WRAP, 1'b0);
    end
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rstsig = 1'b0;
    step   = 1'b0;

    // Reset held 3 cycles with step toggling.
    for (int i = 0; i < 3; i++) begin
      step = ~step;
      tick();
      chk_all("rst", i, 0, 1, 0, 0);
    end
    step  = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_all("rel", 0, 0, 1, 0, 0);

    // Step edges in IDLE are ignored.
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++) add(1'b0, (c < 2), 0, 1'b1, 1'b0, 1'b0);
    // Full run.
    add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= STAGES; k++) add_pulse(k);
    // Restart at sel=4 coinciding with a step edge, then a full run.
    add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) add_pulse(k);
    add(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= STAGES; k++) add_pulse(k);
    // Held step counts once.
    add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) add(1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      rstsig = tbl[i].rs;
      step   = tbl[i].st;
      tick();
      chk_all("vec", i, int'(tbl[i].sel), int'(tbl[i].ml), int'(tbl[i].bz), int'(tbl[i].dn));
    end

    // Async reset mid-run at sel=5, observed before the next clock edge.
    rstsig = 1'b1; step = 1'b0;
    tick();
    rstsig = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end
    chk_all("pre_async", 0, 5, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async", 0, 0, 1, 0, 0);
    tick();
    rst_n = 1'b1;
    // After reset the sequencer is idle: steps do nothing until rstsig.
    step = 1'b1; tick();
    step = 1'b0; tick();
    chk_all("post_async", 0, 0, 1, 0, 0);
    rstsig = 1'b1; tick();
    rstsig = 1'b0;
    chk_all("post_start", 0, 0, 0, 1, 0);
    step = 1'b1; tick();
    chk_all("post_step", 0, 1, 0, 1, 0);
    step = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
